// File: rtl/wb_pkg.sv
// Shared Wishbone data-port definitions: access-type codes used by the hart
// and the arbiter state encoding.
package wb_pkg;

    localparam logic [2:0] DATA_B  = 3'b000;
    localparam logic [2:0] DATA_H  = 3'b001;
    localparam logic [2:0] DATA_W  = 3'b010;
    localparam logic [2:0] DATA_BU = 3'b100;
    localparam logic [2:0] DATA_HU = 3'b101;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin picker. On a tie the master that was not granted last
// wins; last_grant resets to 1 so master 0 takes the first tie.
module rr_grant2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (update && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/wb_data_arbiter.sv
// Shares one Wishbone-classic data slave between the hart (M0) and a secondary
// requester (M1), one registered transaction at a time, with a hung-slave watchdog.
module wb_data_arbiter
    import wb_pkg::*;
#(
    parameter int W       = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_m0_stb,
    input  logic         i_m0_we,
    input  logic [2:0]   i_m0_sel,
    input  logic [W-1:0] i_m0_addr,
    input  logic [W-1:0] i_m0_data,
    input  logic         i_m1_stb,
    input  logic         i_m1_we,
    input  logic [2:0]   i_m1_sel,
    input  logic [W-1:0] i_m1_addr,
    input  logic [W-1:0] i_m1_data,
    output logic         o_m0_ack,
    output logic         o_m0_err,
    output logic [W-1:0] o_m0_data,
    output logic         o_m1_ack,
    output logic         o_m1_err,
    output logic [W-1:0] o_m1_data,
    output logic         o_wb_stb,
    output logic         o_wb_we,
    output logic [2:0]   o_wb_sel,
    output logic [W-1:0] o_wb_addr,
    output logic [W-1:0] o_wb_data,
    input  logic         i_wb_ack,
    input  logic [W-1:0] i_wb_data
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST_ACK = TW'(TIMEOUT - 1);

    arb_state_t    state;
    logic [1:0]    grant;
    logic          gnt_id;
    logic          ok;
    logic [TW-1:0] timer;
    logic [W-1:0]  rdata;

    rr_grant2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({i_m1_stb, i_m0_stb}),
        .update (state == ARB_IDLE),
        .grant  (grant)
    );

    // A response pulse is dropped when the granted master has already
    // withdrawn its strobe; the slave cycle itself is never aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            gnt_id    <= 1'b0;
            ok        <= 1'b0;
            timer     <= '0;
            rdata     <= '0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_sel  <= 3'b000;
            o_wb_addr <= '0;
            o_wb_data <= '0;
            o_m0_ack  <= 1'b0;
            o_m0_err  <= 1'b0;
            o_m0_data <= '0;
            o_m1_ack  <= 1'b0;
            o_m1_err  <= 1'b0;
            o_m1_data <= '0;
        end else begin
            o_m0_ack  <= 1'b0;
            o_m0_err  <= 1'b0;
            o_m0_data <= '0;
            o_m1_ack  <= 1'b0;
            o_m1_err  <= 1'b0;
            o_m1_data <= '0;
            case (state)
                ARB_IDLE: begin
                    if (grant != 2'b00) begin
                        gnt_id    <= grant[1];
                        o_wb_we   <= grant[1] ? i_m1_we   : i_m0_we;
                        o_wb_sel  <= grant[1] ? i_m1_sel  : i_m0_sel;
                        o_wb_addr <= grant[1] ? i_m1_addr : i_m0_addr;
                        o_wb_data <= grant[1] ? i_m1_data : i_m0_data;
                        o_wb_stb  <= 1'b1;
                        timer     <= '0;
                        state     <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (timer != TMAX) begin
                        timer <= timer + 1'b1;
                    end
                    // An ack arriving on the final allowed cycle still counts as success.
                    if (i_wb_ack) begin
                        rdata    <= i_wb_data;
                        ok       <= 1'b1;
                        o_wb_stb <= 1'b0;
                        state    <= ARB_RESP;
                    end else if (timer >= TLAST_ACK) begin
                        ok       <= 1'b0;
                        o_wb_stb <= 1'b0;
                        state    <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (!gnt_id && i_m0_stb) begin
                        o_m0_ack  <= ok;
                        o_m0_err  <= !ok;
                        o_m0_data <= ok ? rdata : '0;
                    end
                    if (gnt_id && i_m1_stb) begin
                        o_m1_ack  <= ok;
                        o_m1_err  <= !ok;
                        o_m1_data <= ok ? rdata : '0;
                    end
                    state <= ARB_IDLE;
                end
                default: begin
                    o_wb_stb <= 1'b0;
                    state    <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_data_arbiter.md
# wb_data_arbiter

Two-master arbiter that shares one Wishbone-classic data slave (block RAM / MMIO space) between the hart data port (M0) and a secondary requester such as the firmware loader or a DMA engine (M1). It grants masters round-robin and owns the slave bus for one complete transaction at a time. It registers all slave-side signals and returns a registered ack or error to the granted master. A timeout watchdog converts a hung slave cycle into an error response so the hart never deadlocks.

## Interface
- `W`, 32, address/data width
- `TIMEOUT`, 15, max cycles a slave cycle may stay unacked before error (≥1)
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  asynchronous active-low reset
- `i_m0_stb` / `i_m1_stb`  in  1  master request, level, held until ack/err
- `i_m0_we` / `i_m1_we`  in  1  write enable
- `i_m0_sel` / `i_m1_sel`  in  3  access type (DATA_B/H/W/BU/HU code)
- `i_m0_addr` / `i_m1_addr`  in  W  byte address
- `i_m0_data` / `i_m1_data`  in  W  write data
- `o_m0_ack` / `o_m1_ack`  out  1  one-cycle completion pulse
- `o_m0_err` / `o_m1_err`  out  1  one-cycle timeout pulse
- `o_m0_data` / `o_m1_data`  out  W  read data, valid with ack
- `o_wb_stb`, `o_wb_we`  out  1  slave strobe / write enable
- `o_wb_sel`  out  3  slave access type
- `o_wb_addr`, `o_wb_data`  out  W  slave address / write data
- `i_wb_ack`  in  1  slave completion
- `i_wb_data`  in  W  slave read data

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: sample both stb. Zero requests stays in IDLE. One request grants that master. Two requests grant the master not granted last (`last_grant`, reset = 1, so M0 wins the first tie). On grant, latch we/sel/addr/data into slave regs, set `o_wb_stb`=1, clear timer, go to BUSY.
- BUSY: slave signals held constant. `i_wb_ack`=1 → latch `i_wb_data`, drop `o_wb_stb`, go to RESP with ok. Timer reaching TIMEOUT without ack → drop `o_wb_stb`, go to RESP with error. Ack on the same cycle as timeout → ack wins.
- RESP: pulse `o_mX_ack` (ok) or `o_mX_err` (error) for the granted master only. The pulse is gated by that master's stb still being high; otherwise it is silently dropped. Read data = latched slave data on ok, 0 on error. Go to IDLE. The RESP→IDLE turnaround is mandatory, even when requests are pending.
- Master stb falling during BUSY does not abort the slave cycle; the cycle completes.
- Non-granted master sees no ack/err and its output data is 0.
- Timer: width clog2(TIMEOUT+1), saturating, counts BUSY cycles only.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `last_grant`=1, all outputs 0 (stb, we, sel, addr, data, acks, errs, master data).
- Req sampled at edge E0 → `o_wb_stb` high after E0.
- Slave ack seen at edge Ek → master ack high for the cycle after Ek+1.
- Minimum latency, stb high to master ack high: 2 edges.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- Error pulse occurs after edge E0+TIMEOUT+1.
- Outputs are registered only; no comb path from any input to any output.

## Structure
- Shared `wb_pkg`: DATA_B/H/W/BU/HU sel codes (shared with hart), arbiter state enum.
- One sub-module `rr_grant2`: 2-way round-robin picker holding `last_grant`. Inputs: req[1:0], update. Outputs: one-hot grant.
- Timer and FSM inline.

## Test plan
- Single M0 read, slave acks 1 cycle after stb with 0xDEADBEEF → `o_m0_ack` pulse 2 edges after request, `o_m0_data`=0xDEADBEEF, M1 outputs 0.
- Simultaneous M0+M1 writes from reset → M0 served first, then M1 after turnaround. Repeat the tie → M1 first (alternation).
- M1 write to addr 0x100, sel=DATA_H, data 0x1234 → slave sees addr 0x100, sel 3'b001, we=1, data stable until ack.
- Slave never acks, TIMEOUT=15 → `o_wb_stb` drops after 15 BUSY cycles, one `o_m0_err` pulse, data 0. Ack on cycle 15 exactly → ack, no err.
- M0 drops stb mid-BUSY → slave cycle still completes, no ack pulse, next IDLE grants M1.
- rst_n asserted during BUSY → all outputs 0 immediately (async). After release, an M0/M1 tie grants M0.
